// File: rtl/dma_master.sv
// Single-channel DMA initiator: arbitrates with req/gnt, then copies units as read/write pairs.
// Costs 3 cycles per unit plus 1 REQ and 1 DONE cycle when gnt and ok are high; bus_ok low holds the current access.
module dma_master #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_word,
  input  logic [1:0]       cfg_src_ctl,
  input  logic [1:0]       cfg_dst_ctl,
  output logic             busy,
  output logic             done_irq,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  output logic [1:0]       bus_width,
  output logic             bus_read,
  output logic             bus_write,
  input  logic             bus_ok
);

  typedef enum logic [2:0] {IDLE, REQ, RD_A, RD_D, WR, DONE} state_t;

  state_t           state, nxt;
  logic [31:0]      src_q, dst_q, rdata_q;
  logic [CNT_W:0]   rem_q;
  logic             word_q;
  logic [1:0]       src_ctl_q, dst_ctl_q;
  logic             aborted_q;

  function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] ctl,
                                            input logic w);
    logic [31:0] s;
    s = w ? 32'd4 : 32'd2;
    case (ctl)
      2'b01:   step_addr = a - s;
      2'b10:   step_addr = a;
      default: step_addr = a + s;
    endcase
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a, input logic w);
    align = w ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = REQ;
      REQ: begin
        if (abort)        nxt = DONE;
        else if (bus_gnt) nxt = RD_A;
      end
      RD_A: nxt = RD_D;
      RD_D: if (bus_ok) nxt = WR;
      WR: begin
        if (bus_ok) nxt = (rem_q == (CNT_W+1)'(1) || abort) ? DONE : RD_A;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: a zero count loads 2**CNT_W so the full range is reachable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      rdata_q   <= '0;
      rem_q     <= '0;
      word_q    <= 1'b1;
      src_ctl_q <= '0;
      dst_ctl_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q     <= align(cfg_src, cfg_word);
            dst_q     <= align(cfg_dst, cfg_word);
            rem_q     <= (cfg_count == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, cfg_count};
            word_q    <= cfg_word;
            src_ctl_q <= cfg_src_ctl;
            dst_ctl_q <= cfg_dst_ctl;
            aborted_q <= 1'b0;
          end
        end
        REQ: if (abort) aborted_q <= 1'b1;
        RD_D: if (bus_ok) rdata_q <= bus_rdata;
        WR: begin
          if (bus_ok) begin
            rem_q <= rem_q - (CNT_W+1)'(1);
            src_q <= step_addr(src_q, src_ctl_q, word_q);
            dst_q <= step_addr(dst_q, dst_ctl_q, word_q);
            if (abort) aborted_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_width = word_q ? 2'h2 : 2'h1;

  always_comb begin
    busy      = (state != IDLE);
    done_irq  = 1'b0;
    bus_req   = 1'b0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      REQ: bus_req = 1'b1;
      RD_A, RD_D: begin
        bus_req  = 1'b1;
        bus_read = 1'b1;
        bus_addr = src_q;
      end
      WR: begin
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = dst_q;
        bus_wdata = word_q ? rdata_q : {16'h0, rdata_q[15:0]};
      end
      DONE: done_irq = !aborted_q;
      default: ;
    endcase
  end

endmodule
